page_table_walker: RTL

PAGE_TABLE_WALKER -- requirements
Module: page_table_walker

---
 rtl/page_table_walker.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/page_table_walker.sv
// Two-level (10/10/12) page table walker with one outstanding PTE read.
// Every output is a flop; the _d values are decoded from the PTE in the cycle it arrives.
module page_table_walker #(
  parameter logic [31:0] PT_BASE = 32'h0008_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ptw_req_valid_i,
  output logic        ptw_req_ready_o,
  input  logic [31:0] ptw_vaddr_i,
  output logic        ptw_resp_valid_o,
  input  logic        ptw_resp_ready_i,
  output logic [31:0] ptw_pte_o,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [31:0] mem_addr_o,
  input  logic        mem_resp_valid_i,
  output logic        mem_resp_ready_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [2:0] {IDLE, L1_REQ, L1_WAIT, L2_REQ, L2_WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [31:0] vaddr_q, vaddr_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] pte_q, pte_d;
  logic        mem_req_valid_q, mem_req_valid_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_resp_ready_q, mem_resp_ready_d;

  logic        pte_v, pte_rw, l1_pointer, l1_leaf_ok, l2_leaf_ok;
  logic [31:0] l1_leaf_pte, l2_leaf_pte, l2_addr;
  logic        unused_bits;

  assign pte_v       = mem_rdata_i[2];
  assign pte_rw      = |mem_rdata_i[1:0];
  assign l1_pointer  = pte_v & ~pte_rw;
  // A superpage must be 4 MiB aligned: its low PPN bits are replaced by vaddr[21:12].
  assign l1_leaf_ok  = pte_v & pte_rw & (mem_rdata_i[21:12] == 10'd0);
  assign l2_leaf_ok  = pte_v & pte_rw;
  assign l1_leaf_pte = {mem_rdata_i[31:22], vaddr_q[21:12], 9'd0, 1'b1, mem_rdata_i[1:0]};
  assign l2_leaf_pte = {mem_rdata_i[31:12], 9'd0, 1'b1, mem_rdata_i[1:0]};
  assign l2_addr     = {mem_rdata_i[31:12], 12'd0} + {20'd0, vaddr_q[21:12], 2'b00};
  assign unused_bits = ^{mem_rdata_i[11:3], vaddr_q[11:0], vaddr_q[31:22]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= IDLE;
      vaddr_q          <= 32'd0;
      req_ready_q      <= 1'b1;
      resp_valid_q     <= 1'b0;
      pte_q            <= 32'd0;
      mem_req_valid_q  <= 1'b0;
      mem_addr_q       <= 32'd0;
      mem_resp_ready_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      vaddr_q          <= vaddr_d;
      req_ready_q      <= req_ready_d;
      resp_valid_q     <= resp_valid_d;
      pte_q            <= pte_d;
      mem_req_valid_q  <= mem_req_valid_d;
      mem_addr_q       <= mem_addr_d;
      mem_resp_ready_q <= mem_resp_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ptw_req_valid_i) state_d = L1_REQ;
      L1_REQ:  if (mem_req_ready_i) state_d = L1_WAIT;
      L1_WAIT: if (mem_resp_valid_i) state_d = l1_pointer ? L2_REQ : RESP;
      L2_REQ:  if (mem_req_ready_i) state_d = L2_WAIT;
      L2_WAIT: if (mem_resp_valid_i) state_d = RESP;
      RESP:    if (ptw_resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vaddr_d          = vaddr_q;
    req_ready_d      = req_ready_q;
    resp_valid_d     = resp_valid_q;
    pte_d            = pte_q;
    mem_req_valid_d  = mem_req_valid_q;
    mem_addr_d       = mem_addr_q;
    mem_resp_ready_d = mem_resp_ready_q;
    case (state_q)
      IDLE: begin
        if (ptw_req_valid_i) begin
          vaddr_d         = ptw_vaddr_i;
          req_ready_d     = 1'b0;
          mem_req_valid_d = 1'b1;
          mem_addr_d      = PT_BASE + {20'd0, ptw_vaddr_i[31:22], 2'b00};
        end
      end
      L1_REQ, L2_REQ: begin
        if (mem_req_ready_i) begin
          mem_req_valid_d  = 1'b0;
          mem_resp_ready_d = 1'b1;
        end
      end
      L1_WAIT: begin
        if (mem_resp_valid_i) begin
          mem_resp_ready_d = 1'b0;
          if (l1_pointer) begin
            mem_req_valid_d = 1'b1;
            mem_addr_d      = l2_addr;
          end else begin
            resp_valid_d = 1'b1;
            pte_d        = l1_leaf_ok ? l1_leaf_pte : 32'd0;
          end
        end
      end
      L2_WAIT: begin
        if (mem_resp_valid_i) begin
          mem_resp_ready_d = 1'b0;
          resp_valid_d     = 1'b1;
          pte_d            = l2_leaf_ok ? l2_leaf_pte : 32'd0;
        end
      end
      RESP: begin
        if (ptw_resp_ready_i) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign ptw_req_ready_o  = req_ready_q;
  assign ptw_resp_valid_o = resp_valid_q;
  assign ptw_pte_o        = pte_q;
  assign mem_req_valid_o  = mem_req_valid_q;
  assign mem_addr_o       = mem_addr_q;
  assign mem_resp_ready_o = mem_resp_ready_q;

endmodule
